// File: rtl/bsg_pipe_reset_en.sv
// Elastic, bubble-collapsing register pipeline of depth_p stages with per-stage valid bits.
// Define BSG_PIPE_FLUSH_EN to add flush_i, which clears all valid bits but keeps data.
module bsg_pipe_reset_en #(
  parameter int unsigned         width_p     = 28,
  parameter int unsigned         depth_p     = 2,
  parameter logic [width_p-1:0]  reset_val_p = '0,
  localparam int unsigned        count_w_lp  = $clog2(depth_p + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
`ifdef BSG_PIPE_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  v_i,
  input  logic [width_p-1:0]    data_i,
  output logic                  ready_o,
  output logic                  v_o,
  output logic [width_p-1:0]    data_o,
  input  logic                  yumi_i,
  output logic [count_w_lp-1:0] count_o
);

  logic [depth_p-1:0] r_valid;
  logic [width_p-1:0] r_data [depth_p];

  logic               w_flush;
  logic               w_stall;
  logic [depth_p:0]   w_free;
  logic [depth_p-1:0] w_move;
  logic [depth_p-1:0] w_load;
  logic [depth_p-1:0] w_valid_d;
  logic [count_w_lp-1:0] w_count;

`ifdef BSG_PIPE_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Reset and flush freeze all movement so nothing is accepted or delivered.
  assign w_stall = reset_i | w_flush;

  // w_free[k] means slot k is empty or empties this cycle; walks from the output back to the input.
  always_comb begin
    w_free          = '0;
    w_move          = '0;
    w_free[depth_p] = yumi_i;
    for (int k = int'(depth_p) - 1; k >= 0; k--) begin
      w_move[k] = r_valid[k] & w_free[k+1] & ~w_stall;
      w_free[k] = ~r_valid[k] | w_move[k];
    end
  end

  assign ready_o = ~w_stall & w_free[0];

  always_comb begin
    w_load    = '0;
    w_load[0] = v_i & ready_o;
    for (int k = 1; k < int'(depth_p); k++) begin
      w_load[k] = w_move[k-1];
    end
    w_valid_d = w_load | (r_valid & ~w_move);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid <= '0;
      for (int k = 0; k < int'(depth_p); k++) begin
        r_data[k] <= reset_val_p;
      end
    end else if (w_flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_d;
      if (w_load[0]) r_data[0] <= data_i;
      for (int k = 1; k < int'(depth_p); k++) begin
        if (w_load[k]) r_data[k] <= r_data[k-1];
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < int'(depth_p); k++) begin
      w_count = w_count + count_w_lp'(r_valid[k]);
    end
  end

  assign count_o = w_count;
  assign v_o     = r_valid[depth_p-1];
  assign data_o  = r_data[depth_p-1];

endmodule

// File: tb/tb_bsg_pipe_reset_en.sv
// Bench for bsg_pipe_reset_en: directed scenarios plus random traffic against a word-position model.
// Flush scenario is compiled in only when BSG_PIPE_FLUSH_EN is defined.
module tb_bsg_pipe_reset_en;

  localparam int          D  = 3;
  localparam logic [27:0] RV = 28'hABCDEF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        v3 = 1'b0, y3 = 1'b0;
  logic [27:0] d3 = '0;
  logic        rdy3, vo3;
  logic [27:0] do3;
  logic [1:0]  cnt3;

  logic        b_v = 1'b0, b_y = 1'b0;
  logic [27:0] b_d = '0;
  logic        rdy4, vo4;
  logic [27:0] do4;
  logic [2:0]  cnt4;

  bsg_pipe_reset_en #(.width_p(28), .depth_p(3), .reset_val_p(RV)) u_d3 (
    .clk_i   (clk),
    .reset_i (rst),
`ifdef BSG_PIPE_FLUSH_EN
    .flush_i (1'b0),
`endif
    .v_i     (v3),
    .data_i  (d3),
    .ready_o (rdy3),
    .v_o     (vo3),
    .data_o  (do3),
    .yumi_i  (y3),
    .count_o (cnt3)
  );

  bsg_pipe_reset_en #(.width_p(28), .depth_p(4)) u_d4 (
    .clk_i   (clk),
    .reset_i (rst),
`ifdef BSG_PIPE_FLUSH_EN
    .flush_i (1'b0),
`endif
    .v_i     (b_v),
    .data_i  (b_d),
    .ready_o (rdy4),
    .v_o     (vo4),
    .data_o  (do4),
    .yumi_i  (b_y),
    .count_o (cnt4)
  );

`ifdef BSG_PIPE_FLUSH_EN
  logic        f_v = 1'b0, f_fl = 1'b0;
  logic [27:0] f_d = '0;
  logic        rdy2, vo2;
  logic [27:0] do2;
  logic [1:0]  cnt2;

  bsg_pipe_reset_en #(.width_p(28), .depth_p(2)) u_d2 (
    .clk_i   (clk),
    .reset_i (rst),
    .flush_i (f_fl),
    .v_i     (f_v),
    .data_i  (f_d),
    .ready_o (rdy2),
    .v_o     (vo2),
    .data_o  (do2),
    .yumi_i  (1'b0),
    .count_o (cnt2)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: FIFO of words, each tagged with the stage it occupies (D-1 is the output).
  int          m_pos[$];
  logic [27:0] m_dat[$];
  int          n_pos[$];
  logic [27:0] m_last;
  bit          m_rdy;

  function automatic bit mv();
    return (m_pos.size() > 0) && (m_pos[0] == D - 1);
  endfunction

  // Each word advances one slot unless the word ahead (after its own move) is in the way.
  task automatic predict(input bit yumi, input bit r);
    int lim, np;
    n_pos = {};
    lim   = D;
    if (r) begin
      m_rdy = 1'b0;
      return;
    end
    foreach (m_pos[i]) begin
      if (i == 0 && m_pos[0] == D - 1) begin
        np  = yumi ? -1 : D - 1;
        lim = yumi ? D : D - 1;
      end else begin
        np  = (m_pos[i] + 1 < lim - 1) ? m_pos[i] + 1 : lim - 1;
        lim = np;
      end
      n_pos.push_back(np);
    end
    m_rdy = (lim > 0);
  endtask

  task automatic commit(input bit v, input logic [27:0] d, input bit r);
    if (r) begin
      m_pos  = {};
      m_dat  = {};
      m_last = RV;
      return;
    end
    foreach (n_pos[i]) begin
      m_pos[i] = n_pos[i];
      if (n_pos[i] == D - 1) m_last = m_dat[i];
    end
    if (m_pos.size() > 0 && m_pos[0] < 0) begin
      void'(m_pos.pop_front());
      void'(m_dat.pop_front());
    end
    if (v && m_rdy) begin
      m_pos.push_back(0);
      m_dat.push_back(d);
    end
  endtask

  logic        obs_v, obs_r;
  logic [27:0] obs_d;
  logic [1:0]  obs_c;

  task automatic cyc(input bit v, input logic [27:0] d, input bit y, input bit r);
    @(negedge clk);
    rst = r; v3 = v; d3 = d; y3 = y;
    predict(y, r);
    #1;
    obs_v = vo3; obs_d = do3; obs_c = cnt3; obs_r = rdy3;
    chk("m_v_o",     32'(vo3),  32'(mv()));
    chk("m_data_o",  32'(do3),  32'(m_last));
    chk("m_count_o", 32'(cnt3), 32'(m_pos.size()));
    chk("m_ready_o", 32'(rdy3), 32'(m_rdy));
    @(posedge clk);
    #1;
    commit(v, d, r);
  endtask

  initial begin
    logic [27:0] w [4];
    logic        rv, rr, ry;
    w = '{28'h00000A1, 28'h00000B2, 28'h00000C3, 28'h00000D4};

    repeat (2) @(posedge clk);
    #1;
    commit(1'b0, '0, 1'b1);

    // Reset values
    cyc(0, '0, 0, 0);
    chk("rst_v_o", 32'(obs_v), 32'd0);
    chk("rst_data_o", 32'(obs_d), 32'(RV));
    chk("rst_count_o", 32'(obs_c), 32'd0);
    chk("rst_ready_o", 32'(obs_r), 32'd1);
    chk("rst_d4_v_o", 32'(vo4), 32'd0);
    chk("rst_d4_data_o", 32'(do4), 32'd0);

    // Latency / throughput with yumi following v_o
    for (int i = 0; i < 10; i++) begin
      cyc(i < 5, 28'(i + 1), mv(), 0);
      chk("lat_v_o", 32'(obs_v), 32'(i >= 3 && i <= 7));
      if (i >= 3 && i <= 7) chk("lat_data_o", 32'(obs_d), 32'(i - 2));
      if (i < 5) chk("lat_ready_o", 32'(obs_r), 32'd1);
    end

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      cyc(1, w[i], 0, 0);
      chk("bp_ready_o", 32'(obs_r), 32'(i < 3));
    end
    chk("bp_count_o", 32'(obs_c), 32'd3);
    cyc(1, w[3], 1, 0);
    chk("bp_accept_d", 32'(obs_r), 32'd1);
    chk("bp_data_a", 32'(obs_d), 32'(w[0]));
    cyc(0, '0, 0, 0);
    chk("bp_data_b", 32'(obs_d), 32'(w[1]));
    chk("bp_v_b", 32'(obs_v), 32'd1);
    repeat (6) cyc(0, '0, mv(), 0);

    // Bubble collapse on the depth-4 instance
    b_v = 1; b_d = 28'h1111111;
    chk("bb_ready_x", 32'(rdy4), 32'd1);
    cyc(0, '0, 0, 0);
    b_v = 0;
    repeat (2) cyc(0, '0, 0, 0);
    b_v = 1; b_d = 28'h2222222;
    chk("bb_ready_y", 32'(rdy4), 32'd1);
    cyc(0, '0, 0, 0);
    b_v = 0;
    repeat (3) cyc(0, '0, 0, 0);
    chk("bb_count_o", 32'(cnt4), 32'd2);
    chk("bb_v_x", 32'(vo4), 32'd1);
    chk("bb_data_x", 32'(do4), 32'h1111111);
    b_y = 1;
    cyc(0, '0, 0, 0);
    b_y = 0;
    chk("bb_v_y", 32'(vo4), 32'd1);
    chk("bb_data_y", 32'(do4), 32'h2222222);
    chk("bb_count_y", 32'(cnt4), 32'd1);
    b_y = 1;
    cyc(0, '0, 0, 0);
    b_y = 0;
    chk("bb_empty", 32'(vo4), 32'd0);

    // Reset mid-flight with yumi asserted
    for (int i = 0; i < 3; i++) cyc(1, 28'(100 + i), 0, 0);
    cyc(0, '0, 1, 1);
    chk("mid_ready_in_rst", 32'(obs_r), 32'd0);
    cyc(0, '0, 0, 0);
    chk("mid_v_o", 32'(obs_v), 32'd0);
    chk("mid_count_o", 32'(obs_c), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, mv(), 0);
      chk("mid_no_word", 32'(obs_v), 32'd0);
    end

`ifdef BSG_PIPE_FLUSH_EN
    // Flush on the depth-2 instance
    f_v = 1; f_d = 28'h0000F01;
    cyc(0, '0, 0, 0);
    f_d = 28'h0000F02;
    cyc(0, '0, 0, 0);
    f_v = 0;
    chk("fl_full", 32'(cnt2), 32'd2);
    chk("fl_data_p", 32'(do2), 32'h0000F01);
    f_v = 1; f_d = 28'h0000F03; f_fl = 1;
    chk("fl_ready_o", 32'(rdy2), 32'd0);
    cyc(0, '0, 0, 0);
    f_v = 0; f_fl = 0;
    chk("fl_v_o", 32'(vo2), 32'd0);
    chk("fl_count_o", 32'(cnt2), 32'd0);
    chk("fl_data_hold", 32'(do2), 32'h0000F01);
    f_v = 1; f_d = 28'h0000F04;
    chk("fl_ready_after", 32'(rdy2), 32'd1);
    cyc(0, '0, 0, 0);
    f_v = 0;
    cyc(0, '0, 0, 0);
    chk("fl_v_s", 32'(vo2), 32'd1);
    chk("fl_data_s", 32'(do2), 32'h0000F04);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 1));
      ry = 1'($urandom_range(0, 3) != 0);
      rr = 1'($urandom_range(0, 59) == 0);
      cyc(rv, 28'($urandom), mv() & ry, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
